cmap_stream_decoder: RTL and testbench

//  Streaming zero/non-zero bitmap (ZNZ) decompressor. Packed non-zero words arrive on a

---
 rtl/cmap_stream_decoder_if.sv | 29 ++
 rtl/cmap_stream_decoder.sv | 112 +++++++++++
 tb/tb_cmap_stream_decoder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cmap_stream_decoder_if.sv
// rtl/cmap_stream_decoder_if.sv - bitmap, packed-word and decoded-vector streams of the ZNZ decoder
interface cmap_stream_decoder_if #(
  parameter int ZNZ_BITS = 8,
  parameter int DATA_W   = 8,
  parameter int IN_LANES = 4
) ();
  localparam int CNT_W = $clog2(IN_LANES + 1);

  logic                               znz_valid;
  logic                               znz_ready;
  logic [ZNZ_BITS-1:0]                znz_din;
  logic                               enc_valid;
  logic                               enc_ready;
  logic [CNT_W-1:0]                   enc_cnt;
  logic [IN_LANES-1:0][DATA_W-1:0]    enc_din;
  logic                               dec_valid;
  logic                               dec_ready;
  logic [ZNZ_BITS-1:0][DATA_W-1:0]    dec_dout;

  modport master (
    output znz_valid, znz_din, enc_valid, enc_cnt, enc_din, dec_ready,
    input  znz_ready, enc_ready, dec_valid, dec_dout
  );

  modport slave (
    input  znz_valid, znz_din, enc_valid, enc_cnt, enc_din, dec_ready,
    output znz_ready, enc_ready, dec_valid, dec_dout
  );
endinterface

// File: rtl/cmap_stream_decoder.sv
// rtl/cmap_stream_decoder.sv - zero/non-zero bitmap decompressor: buffers packed words, scatters them per bitmap
module cmap_stream_decoder #(
  parameter int ZNZ_BITS  = 8,
  parameter int DATA_W    = 8,
  parameter int IN_LANES  = 4,
  parameter int BUF_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  cmap_stream_decoder_if.slave             bus,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_level,
  output logic                             cnt_err
);
  localparam int CNT_W = $clog2(IN_LANES + 1);
  localparam int LVL_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  localparam logic [CNT_W-1:0] LANES_C   = CNT_W'(IN_LANES);
  localparam logic [LVL_W-1:0] ENC_LIMIT = LVL_W'(BUF_DEPTH - IN_LANES);
  localparam logic [PTR_W:0]   DEPTH_P   = (PTR_W+1)'(BUF_DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  generate
    if (BUF_DEPTH < ZNZ_BITS + IN_LANES) begin : g_depth_check
      $error("BUF_DEPTH must be at least ZNZ_BITS + IN_LANES");
    end
  endgenerate

  // k never exceeds BUF_DEPTH, so one conditional subtract wraps correctly.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [PTR_W:0] k);
    logic [PTR_W:0] s;
    s = {1'b0, p} + k;
    if (s >= DEPTH_P) s = s - DEPTH_P;
    return s[PTR_W-1:0];
  endfunction

  logic [DATA_W-1:0]               mem [BUF_DEPTH];
  logic [PTR_W-1:0]                rd_ptr, wr_ptr;
  logic [LVL_W-1:0]                level;
  logic [0:0]                      state;
  logic [ZNZ_BITS-1:0]             map;
  logic [LVL_W-1:0]                need, pop_cnt;
  logic [CNT_W-1:0]                push_cnt;
  logic                            fire, enc_fire, znz_fire;
  logic                            dec_valid_q;
  logic [ZNZ_BITS-1:0][DATA_W-1:0] dec_next, dec_dout_q;

  assign buf_level     = level;
  assign bus.enc_ready = (level <= ENC_LIMIT);
  assign enc_fire      = bus.enc_valid && bus.enc_ready;
  assign fire          = (state == S_HOLD) && (need <= level) && (!dec_valid_q || bus.dec_ready);
  assign bus.znz_ready = (state == S_IDLE) || fire;
  assign znz_fire      = bus.znz_valid && bus.znz_ready;
  assign pop_cnt       = fire ? need : '0;
  assign bus.dec_valid = dec_valid_q;
  assign bus.dec_dout  = dec_dout_q;

  always_comb begin
    push_cnt = '0;
    if (enc_fire) push_cnt = (bus.enc_cnt > LANES_C) ? LANES_C : bus.enc_cnt;
  end

  // The running count doubles as each set lane's offset into the buffer.
  always_comb begin
    need     = '0;
    dec_next = '0;
    for (int i = 0; i < ZNZ_BITS; i++) begin
      if (map[i]) begin
        dec_next[i] = mem[ptr_add(rd_ptr, (PTR_W+1)'(need))];
        need        = need + LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      map         <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level       <= '0;
      dec_valid_q <= 1'b0;
      dec_dout_q  <= '0;
      cnt_err     <= 1'b0;
    end else begin
      for (int k = 0; k < IN_LANES; k++) begin
        if (CNT_W'(k) < push_cnt) mem[ptr_add(wr_ptr, (PTR_W+1)'(k))] <= bus.enc_din[k];
      end
      wr_ptr <= ptr_add(wr_ptr, (PTR_W+1)'(push_cnt));
      rd_ptr <= ptr_add(rd_ptr, (PTR_W+1)'(pop_cnt));
      level  <= level + LVL_W'(push_cnt) - pop_cnt;

      if (enc_fire && (bus.enc_cnt > LANES_C)) cnt_err <= 1'b1;

      if (znz_fire) begin
        state <= S_HOLD;
        map   <= bus.znz_din;
      end else if (fire) begin
        state <= S_IDLE;
      end

      if (fire) begin
        dec_valid_q <= 1'b1;
        dec_dout_q  <= dec_next;
      end else if (bus.dec_ready) begin
        dec_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cmap_stream_decoder.sv
// tb/tb_cmap_stream_decoder.sv - directed self-checking bench for cmap_stream_decoder
module tb_cmap_stream_decoder;
  logic       clk;
  logic       rst_n;
  logic [4:0] buf_level;
  logic       cnt_err;
  int         n_cmp;
  int         n_err;

  cmap_stream_decoder_if #(.ZNZ_BITS(8), .DATA_W(8), .IN_LANES(4)) bus ();

  cmap_stream_decoder #(.ZNZ_BITS(8), .DATA_W(8), .IN_LANES(4), .BUF_DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .buf_level (buf_level),
    .cnt_err   (cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.znz_valid = 1'b0;
    bus.znz_din   = '0;
    bus.enc_valid = 1'b0;
    bus.enc_cnt   = '0;
    bus.enc_din   = '0;
  endtask

  initial begin
    int          words_sent;
    int          maps_sent;
    int          out_idx;
    logic [63:0] exp_vec;
    logic        enc_acc, znz_acc;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.dec_ready = 1'b1;
    idle_inputs();
    cycle();
    cycle();

    check("rst_dec_valid", 64'(bus.dec_valid), 64'd0);
    check("rst_dec_dout",  bus.dec_dout,       64'd0);
    check("rst_buf_level", 64'(buf_level),     64'd0);
    check("rst_cnt_err",   64'(cnt_err),       64'd0);
    check("rst_znz_ready", 64'(bus.znz_ready), 64'd1);
    check("rst_enc_ready", 64'(bus.enc_ready), 64'd1);
    rst_n = 1'b1;

    // Test 1: full map, two beats.
    bus.znz_valid = 1'b1;
    bus.znz_din   = 8'hFF;
    bus.enc_valid = 1'b1;
    bus.enc_cnt   = 3'd4;
    bus.enc_din   = {8'd4, 8'd3, 8'd2, 8'd1};
    cycle();
    bus.znz_valid = 1'b0;
    bus.enc_din   = {8'd8, 8'd7, 8'd6, 8'd5};
    #1;
    check("t1_hold_znz_ready", 64'(bus.znz_ready), 64'd0);
    check("t1_level4",         64'(buf_level),     64'd4);
    cycle();
    bus.enc_valid = 1'b0;
    check("t1_level8",         64'(buf_level),     64'd8);
    check("t1_not_yet_valid",  64'(bus.dec_valid), 64'd0);
    cycle();
    check("t1_dec_valid",      64'(bus.dec_valid), 64'd1);
    check("t1_dec_dout",       bus.dec_dout,       64'h0807060504030201);
    check("t1_level0",         64'(buf_level),     64'd0);

    // Test 2: sparse map 1010_0101.
    bus.znz_valid = 1'b1;
    bus.znz_din   = 8'hA5;
    bus.enc_valid = 1'b1;
    bus.enc_cnt   = 3'd4;
    bus.enc_din   = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    cycle();
    idle_inputs();
    check("t2_valid_cleared", 64'(bus.dec_valid), 64'd0);
    check("t2_level4",        64'(buf_level),     64'd4);
    cycle();
    check("t2_dec_valid",     64'(bus.dec_valid), 64'd1);
    check("t2_dec_dout",      bus.dec_dout,       64'hD400C30000B200A1);
    check("t2_level0",        64'(buf_level),     64'd0);

    // Test 3: empty map with empty buffer.
    bus.znz_valid = 1'b1;
    bus.znz_din   = 8'h00;
    cycle();
    idle_inputs();
    cycle();
    check("t3_dec_valid", 64'(bus.dec_valid), 64'd1);
    check("t3_dec_dout",  bus.dec_dout,       64'd0);
    check("t3_level",     64'(buf_level),     64'd0);
    cycle();
    check("t3_valid_drop", 64'(bus.dec_valid), 64'd0);

    // Test 5: over-range count is clamped; zero count appends nothing.
    bus.enc_valid = 1'b1;
    bus.enc_cnt   = 3'd7;
    bus.enc_din   = {8'h14, 8'h13, 8'h12, 8'h11};
    cycle();
    check("t5_level_clamped", 64'(buf_level), 64'd4);
    check("t5_cnt_err_set",   64'(cnt_err),   64'd1);
    bus.enc_cnt = 3'd0;
    bus.enc_din = {8'hEE, 8'hEE, 8'hEE, 8'hEE};
    cycle();
    check("t5_cnt0_level",    64'(buf_level), 64'd4);
    idle_inputs();
    bus.znz_valid = 1'b1;
    bus.znz_din   = 8'h0F;
    cycle();
    idle_inputs();
    cycle();
    check("t5_dec_dout",      bus.dec_dout,   64'h0000000014131211);
    check("t5_level0",        64'(buf_level), 64'd0);
    check("t5_cnt_err_stick", 64'(cnt_err),   64'd1);
    cycle();

    // Test 4: 20 cycles of backpressure, then drain six full-map vectors.
    words_sent = 0;
    maps_sent  = 0;
    out_idx    = 0;
    for (int c = 0; c < 60; c++) begin
      bus.dec_ready = (c >= 20);
      bus.znz_valid = (maps_sent < 6);
      bus.znz_din   = 8'hFF;
      bus.enc_valid = (words_sent < 48);
      bus.enc_cnt   = 3'd4;
      for (int k = 0; k < 4; k++) bus.enc_din[k] = 8'(8'h20 + words_sent + k);
      #1;
      enc_acc = bus.enc_valid && bus.enc_ready;
      znz_acc = bus.znz_valid && bus.znz_ready;
      if (bus.dec_valid && bus.dec_ready) begin
        for (int i = 0; i < 8; i++) exp_vec[i*8 +: 8] = 8'(8'h20 + out_idx*8 + i);
        check("t4_drain_vec", bus.dec_dout, exp_vec);
        out_idx++;
      end
      if (c == 19) begin
        for (int i = 0; i < 8; i++) exp_vec[i*8 +: 8] = 8'(8'h20 + i);
        check("t4_stall_dout",      bus.dec_dout,       exp_vec);
        check("t4_stall_valid",     64'(bus.dec_valid), 64'd1);
        check("t4_stall_level",     64'(buf_level),     64'd16);
        check("t4_stall_enc_ready", 64'(bus.enc_ready), 64'd0);
      end
      cycle();
      if (enc_acc) words_sent += 4;
      if (znz_acc) maps_sent++;
    end
    idle_inputs();
    check("t4_out_count",   64'(out_idx),   64'd6);
    check("t4_final_level", 64'(buf_level), 64'd0);
    cycle();

    // Test 6: reset mid-operation with level 9 and a pending output.
    bus.dec_ready = 1'b0;
    bus.znz_valid = 1'b1;
    bus.znz_din   = 8'h01;
    bus.enc_valid = 1'b1;
    bus.enc_cnt   = 3'd4;
    bus.enc_din   = {8'h34, 8'h33, 8'h32, 8'h31};
    cycle();
    bus.znz_valid = 1'b0;
    cycle();
    bus.enc_cnt = 3'd2;
    cycle();
    idle_inputs();
    check("t6_pre_level",   64'(buf_level),     64'd9);
    check("t6_pre_valid",   64'(bus.dec_valid), 64'd1);
    check("t6_pre_cnt_err", 64'(cnt_err),       64'd1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("t6_rst_level",   64'(buf_level),     64'd0);
    check("t6_rst_valid",   64'(bus.dec_valid), 64'd0);
    check("t6_rst_cnt_err", 64'(cnt_err),       64'd0);
    check("t6_rst_dout",    bus.dec_dout,       64'd0);
    check("t6_rst_znz_rdy", 64'(bus.znz_ready), 64'd1);
    bus.dec_ready = 1'b1;
    bus.znz_valid = 1'b1;
    bus.znz_din   = 8'h42;
    bus.enc_valid = 1'b1;
    bus.enc_cnt   = 3'd2;
    bus.enc_din   = {8'h00, 8'h00, 8'hA5, 8'h5A};
    cycle();
    idle_inputs();
    cycle();
    check("t6_fresh_valid", 64'(bus.dec_valid), 64'd1);
    check("t6_fresh_dout",  bus.dec_dout,       64'h00A5000000005A00);
    check("t6_fresh_level", 64'(buf_level),     64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
